// File: rtl/cic_int_mc.sv
// Multi-channel CIC interpolator with runtime rate, rounding shift and
// output saturation. Combs run at the input rate (accept ticks), the
// integrators and output stage run on every ce tick with zero-stuffing.
module cic_int_mc #(
    parameter int CH        = 2,
    parameter int I_WIDTH   = 16,
    parameter int O_WIDTH   = 16,
    parameter int N         = 5,
    parameter int M         = 1,
    parameter int RMAX      = 2048,
    parameter int REG_WIDTH = 71
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic [$clog2(RMAX+1)-1:0]     rate,
    input  logic [$clog2(REG_WIDTH)-1:0]  shift,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [CH*I_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    output logic [CH*O_WIDTH-1:0]         m_data,
    output logic                          underrun,
    output logic                          sat,
    input  logic                          clr_flags
);

    localparam int RATE_W  = $clog2(RMAX+1);
    localparam int SHIFT_W = $clog2(REG_WIDTH);

    typedef logic signed [REG_WIDTH-1:0] acc_t;

    localparam acc_t ONE  = acc_t'(1);
    localparam acc_t OMAX = {{(REG_WIDTH-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
    localparam acc_t OMIN = {{(REG_WIDTH-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

    logic [RATE_W-1:0] rate_eff;
    logic [RATE_W-1:0] r_l;
    logic [RATE_W-1:0] phase;
    logic [RATE_W-1:0] phase_nxt;
    logic              accept;

    acc_t comb_in [CH][N];
    acc_t comb_r  [CH][N];
    acc_t dly_r   [CH][N][M];
    acc_t integ_r [CH][N];

    acc_t                 rnd_add;
    acc_t                 sum_v   [CH];
    acc_t                 rnd_v   [CH];
    logic [CH-1:0]        clip;
    logic [CH*O_WIDTH-1:0] m_data_nxt;

    // A period always starts on phase 0; that is the only tick where data enters.
    assign accept  = ce && (phase == '0);
    assign s_ready = accept;

    // Clamp the requested rate into 1..RMAX.
    always_comb begin
        rate_eff = rate;
        if (rate == '0)
            rate_eff = RATE_W'(1);
        else if (rate > RATE_W'(RMAX))
            rate_eff = RATE_W'(RMAX);
    end

    // Next phase; at phase 0 the freshly latched rate decides the period length.
    always_comb begin
        phase_nxt = phase + RATE_W'(1);
        if (phase == '0) begin
            if (rate_eff == RATE_W'(1))
                phase_nxt = '0;
        end else if (phase == r_l - RATE_W'(1)) begin
            phase_nxt = '0;
        end
    end

    // Phase counter and rate latch, moving only on ce ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            r_l   <= RATE_W'(1);
        end else if (ce) begin
            phase <= phase_nxt;
            if (phase == '0)
                r_l <= rate_eff;
        end
    end

    // Comb stage inputs: sign-extended sample (zero on underrun), then previous comb.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            comb_in[c][0] = s_valid ? acc_t'(signed'(s_data[c*I_WIDTH +: I_WIDTH])) : '0;
            for (int k = 1; k < N; k++)
                comb_in[c][k] = comb_r[c][k-1];
        end
    end

    // Comb section with M-deep delay lines, clocked by accept ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < N; k++) begin
                    comb_r[c][k] <= '0;
                    for (int j = 0; j < M; j++)
                        dly_r[c][k][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < N; k++) begin
                    comb_r[c][k]   <= comb_in[c][k] - dly_r[c][k][M-1];
                    dly_r[c][k][0] <= comb_in[c][k];
                    for (int j = 1; j < M; j++)
                        dly_r[c][k][j] <= dly_r[c][k][j-1];
                end
            end
        end
    end

    // Integrator section; the first stage sees the comb output only at phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < N; k++)
                    integ_r[c][k] <= '0;
        end else if (ce) begin
            for (int c = 0; c < CH; c++) begin
                integ_r[c][0] <= integ_r[c][0] + ((phase == '0) ? comb_r[c][N-1] : '0);
                for (int k = 1; k < N; k++)
                    integ_r[c][k] <= integ_r[c][k] + integ_r[c][k-1];
            end
        end
    end

    // Round-half-up bias for the output shift.
    always_comb begin
        rnd_add = '0;
        if (shift != '0)
            rnd_add = ONE << (shift - SHIFT_W'(1));
    end

    // Shift, round and saturate each channel.
    always_comb begin
        m_data_nxt = '0;
        clip       = '0;
        for (int c = 0; c < CH; c++) begin
            sum_v[c] = integ_r[c][N-1] + rnd_add;
            rnd_v[c] = sum_v[c] >>> shift;
            if (rnd_v[c] > OMAX) begin
                m_data_nxt[c*O_WIDTH +: O_WIDTH] = OMAX[O_WIDTH-1:0];
                clip[c] = 1'b1;
            end else if (rnd_v[c] < OMIN) begin
                m_data_nxt[c*O_WIDTH +: O_WIDTH] = OMIN[O_WIDTH-1:0];
                clip[c] = 1'b1;
            end else begin
                m_data_nxt[c*O_WIDTH +: O_WIDTH] = rnd_v[c][O_WIDTH-1:0];
            end
        end
    end

    // Output register, strobe and sticky flags (a new event beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data   <= '0;
            m_valid  <= 1'b0;
            underrun <= 1'b0;
            sat      <= 1'b0;
        end else begin
            m_valid  <= ce;
            if (ce)
                m_data <= m_data_nxt;
            underrun <= (underrun && !clr_flags) || (accept && !s_valid);
            sat      <= (sat && !clr_flags) || (ce && (|clip));
        end
    end

endmodule
